udp_tx_packer: RTL and testbench
================================

# udp_tx_packer

Upstream feeder for the UDP transmit path. Collects a 16-bit audio/FFT sample stream, packs sample pairs into 32-bit words in an internal FIFO, and once a full payload is buffered it starts a UDP transmission. It drives `tx_start_en`/`tx_byte_num` and answers `tx_req` with a sequence-numbered payload until `tx_done`. Outputs connect directly to the `tx_start_en`, `tx_byte_num`, `tx_data`, `tx_req` and `tx_done` ports of `udp_top`. `des_mac`/`des_ip` are tied to zero at the top level, which selects the default destination.

## Interface
- `PKT_WORDS`, default 64: 32-bit words per UDP payload, header included; valid range 2..256.
- `FIFO_DEPTH`, default 256: FIFO depth in sample pairs; power of two, ≥ `PKT_WORDS`.
- `GAP_CYCLES`, default 100: minimum idle cycles between `tx_done` and the next `tx_start_en`; valid range ≥ 1.
- `HDR_TAG`, default 16'hA55A: upper half of header word.

Ports:
- `gmii_tx_clk`  in  1  sole clock, 125 MHz. One clock; reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous active-low reset.
- `smp_valid`  in  1  sample strobe, one sample per high cycle.
- `smp_data`  in  16  sample value.
- `tx_start_en`  out  1  one-cycle packet start pulse to UDP.
- `tx_byte_num`  out  16  payload bytes, = `PKT_WORDS`*4.
- `tx_data`  out  32  payload word.
- `tx_req`  in  1  UDP request for next payload word.
- `tx_done`  in  1  UDP packet complete pulse.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  stored pairs.
- `overflow`  out  1  sticky: a pair was dropped because the FIFO was full.
- `ovf_clr`  in  1  clears `overflow`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Pairing: the first `smp_valid` latches `smp_data` into the even register. The next one forms the word {even, odd}, with even in [31:16], and writes it to the FIFO in the same cycle.
- If the FIFO is full at the write cycle, the pair is discarded and `overflow` is set. `overflow` is cleared only by `ovf_clr` or reset. If set and clear coincide, set wins.
- FIFO: single-clock, width 32. `fifo_level` increments on write and decrements on pop. A write and a pop in the same cycle leave the level unchanged.
- 16-bit packet sequence counter `seq`, reset value 0. It increments on each `tx_done` and wraps 0xFFFF→0.
- FSM states:
  - IDLE: moves to START when `fifo_level` ≥ `PKT_WORDS`-1.
  - START: `tx_start_en`=1 for exactly one cycle, `tx_byte_num` loaded; then moves to SEND.
  - SEND: serves requests; on `tx_done` moves to GAP.
  - GAP: counts `GAP_CYCLES`, then returns to IDLE.
- SEND word index `widx` starts at 0.
  - Request with `widx`=0: `tx_data` ← {`HDR_TAG`, `seq`}, no pop.
  - Request with 1 ≤ `widx` ≤ `PKT_WORDS`-1: `tx_data` ← FIFO head, pop.
  - Request with `widx` ≥ `PKT_WORDS`: `tx_data` ← 0, no pop.
  - `widx` saturates.
- `tx_done` is ignored outside SEND. `tx_req` is ignored outside SEND.
- Sample intake continues in all states, including during transmission.

## Timing
- Reset values: `tx_start_en`=0, `tx_byte_num`=0, `tx_data`=0, `fifo_level`=0, `overflow`=0, `busy`=0, `seq`=0, FSM=IDLE, pending even sample discarded.
- All outputs are registered.
- `tx_data` updates on the rising edge that samples `tx_req`=1, and holds otherwise.
- Threshold to `tx_start_en`: 1 cycle. The threshold is met in cycle n, START occurs in cycle n+1, and `tx_start_en` is high during n+1.
- `tx_byte_num` is stable from START until the next START.
- Pair write latency: the FIFO entry and `fifo_level` are visible 1 cycle after the odd `smp_valid`.
- A `tx_done` coinciding with `tx_req` serves that request, then goes to GAP.
- GAP length: exactly `GAP_CYCLES` cycles.
- Reset asserted mid-packet aborts immediately with no further `tx_start_en`. The FIFO is emptied.

## Test plan
Scenarios 1–4 use `PKT_WORDS`=4, `FIFO_DEPTH`=8, `GAP_CYCLES`=10.

1. Feed samples 0x0001..0x0006, then drive 4 `tx_req` pulses and a `tx_done`. Required response:
   - one `tx_start_en` pulse with `tx_byte_num`=16;
   - `tx_data` sequence A55A0000, 00010002, 00030004, 00050006;
   - `fifo_level` returns to 0 and `seq`=1.
2. Feed 20 samples with no `tx_req`. Required response: after pair 8, `fifo_level`=8, pairs 9–10 are dropped and `overflow`=1. Then pulse `ovf_clr`: `overflow`=0.
3. Feed samples continuously while `tx_req` pops. Required response: in a same-cycle write and pop, `fifo_level` is unchanged and the data order is preserved across packets.
4. Pulse `tx_done` while 3 more pairs are already buffered. Required response: the next `tx_start_en` comes exactly 11 cycles after `tx_done`, and the header is A55A0001.
5. Drive a 5th and 6th `tx_req` in one packet. Required response: `tx_data`=0 on those requests, with no pop.
6. Assert `rst_n`=0 after the 2nd word of a packet. Required response: all outputs return to their reset values, and the next packet header is A55A0000.

Source files
------------

// File: rtl/udp_tx_packer.sv
// Sample-pair packer feeding udp_top: packs 16-bit samples into 32-bit FIFO
// words and streams a sequence-numbered payload once a full packet is buffered.
module udp_tx_packer #(
    parameter int unsigned PKT_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 256,
    parameter int unsigned GAP_CYCLES = 100,
    parameter logic [15:0] HDR_TAG    = 16'hA55A
) (
    input  logic                          gmii_tx_clk,
    input  logic                          rst_n,
    input  logic                          smp_valid,
    input  logic [15:0]                   smp_data,
    output logic                          tx_start_en,
    output logic [15:0]                   tx_byte_num,
    output logic [31:0]                   tx_data,
    input  logic                          tx_req,
    input  logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic                          busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned IW = $clog2(PKT_WORDS + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    localparam logic [LW-1:0] LP_FULL     = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LP_THRESH   = LW'(PKT_WORDS - 1);
    localparam logic [IW-1:0] LP_WSAT     = IW'(PKT_WORDS);
    localparam logic [GW-1:0] LP_GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_SEND, S_GAP} state_t;

    state_t        r_state;
    state_t        w_next;

    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic [15:0]   r_even;
    logic          r_have_even;
    logic          r_ovf;
    logic [15:0]   r_seq;
    logic [IW-1:0] r_widx;
    logic [GW-1:0] r_gap_cnt;
    logic          r_start;
    logic          r_busy;
    logic [15:0]   r_byte_num;
    logic [31:0]   r_tx_data;

    logic w_pair, w_full, w_wr, w_drop, w_req, w_done;
    logic w_is_hdr, w_is_body, w_pop, w_thresh, w_gap_end;

    assign w_pair    = smp_valid && r_have_even;
    assign w_full    = (r_level == LP_FULL);
    assign w_wr      = w_pair && !w_full;
    assign w_drop    = w_pair && w_full;
    assign w_req     = (r_state == S_SEND) && tx_req;
    assign w_done    = (r_state == S_SEND) && tx_done;
    assign w_is_hdr  = (r_widx == '0);
    assign w_is_body = !w_is_hdr && (r_widx < LP_WSAT);
    assign w_pop     = w_req && w_is_body && (r_level != '0);
    assign w_thresh  = (r_level >= LP_THRESH);
    assign w_gap_end = (r_gap_cnt == LP_GAP_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_thresh) w_next = S_START;
            S_START: w_next = S_SEND;
            S_SEND:  if (w_done) w_next = S_GAP;
            // The last gap cycle doubles as the threshold check, so START
            // lands exactly GAP_CYCLES+1 cycles after tx_done.
            S_GAP:   if (w_gap_end) w_next = w_thresh ? S_START : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_byte_num  <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_start <= (w_next == S_START);
            r_busy  <= (w_next != S_IDLE);
            if (w_next == S_START) r_byte_num <= 16'(PKT_WORDS * 4);
            r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_even      <= '0;
            r_have_even <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (smp_valid) begin
                if (!r_have_even) r_even <= smp_data;
                r_have_even <= !r_have_even;
            end
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop)       r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge gmii_tx_clk) begin
        if (w_wr) r_mem[r_wptr] <= {r_even, smp_data};
    end

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq     <= '0;
            r_widx    <= '0;
            r_tx_data <= '0;
        end else begin
            if (w_done) r_seq <= r_seq + 16'd1;
            if (r_state == S_START)               r_widx <= '0;
            else if (w_req && r_widx != LP_WSAT)  r_widx <= r_widx + 1'b1;
            if (w_req) begin
                if (w_is_hdr)       r_tx_data <= {HDR_TAG, r_seq};
                else if (w_is_body) r_tx_data <= r_mem[r_rptr];
                else                r_tx_data <= '0;
            end
        end
    end

    assign tx_start_en = r_start;
    assign tx_byte_num = r_byte_num;
    assign tx_data     = r_tx_data;
    assign fifo_level  = r_level;
    assign overflow    = r_ovf;
    assign busy        = r_busy;

endmodule

// File: tb/tb_udp_tx_packer.sv
// Directed bench for udp_tx_packer with a 4-word packet, 8-pair FIFO and
// 10-cycle inter-packet gap.
module tb_udp_tx_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        smp_valid = 1'b0;
    logic [15:0] smp_data = '0;
    logic        tx_req = 1'b0;
    logic        tx_done = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic [31:0] tx_data;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic        busy;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;

    udp_tx_packer #(
        .PKT_WORDS (4),
        .FIFO_DEPTH(8),
        .GAP_CYCLES(10),
        .HDR_TAG   (16'hA55A)
    ) dut (
        .gmii_tx_clk(clk),
        .rst_n      (rst_n),
        .smp_valid  (smp_valid),
        .smp_data   (smp_data),
        .tx_start_en(tx_start_en),
        .tx_byte_num(tx_byte_num),
        .tx_data    (tx_data),
        .tx_req     (tx_req),
        .tx_done    (tx_done),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (tx_start_en === 1'b1) start_cnt++;
    end

    task automatic feed(input logic [15:0] d);
        smp_valid = 1'b1;
        smp_data  = d;
        @(negedge clk);
        smp_valid = 1'b0;
    endtask

    task automatic req();
        tx_req = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic wait_start(output int k);
        k = 0;
        while (tx_start_en !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        smp_valid = 1'b0; tx_req = 1'b0; tx_done = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (tx_start_en !== 1'b0) begin bad++; $display("FAIL rst_start got=%b exp=0", tx_start_en); end
        total++; if (tx_byte_num !== 16'd0) begin bad++; $display("FAIL rst_bytes got=%h exp=0000", tx_byte_num); end
        total++; if (tx_data !== 32'd0) begin bad++; $display("FAIL rst_data got=%h exp=00000000", tx_data); end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_packet();
        logic [31:0] exp_w [4] = '{32'hA55A0000, 32'h00010002, 32'h00030004, 32'h00050006};
        int k;
        for (int i = 1; i <= 6; i++) feed(16'(i));
        total++; if (fifo_level !== 4'd3) begin bad++; $display("FAIL basic_level3 got=%0d exp=3", fifo_level); end
        wait_start(k);
        total++; if (k != 1) begin bad++; $display("FAIL basic_start_latency got=%0d exp=1", k); end
        total++; if (tx_byte_num !== 16'd16) begin bad++; $display("FAIL basic_bytes got=%0d exp=16", tx_byte_num); end
        total++; if (start_cnt != 1) begin bad++; $display("FAIL basic_start_cnt got=%0d exp=1", start_cnt); end
        @(negedge clk);
        total++; if (tx_start_en !== 1'b0) begin bad++; $display("FAIL basic_start_width got=%b exp=0", tx_start_en); end
        for (int i = 0; i < 4; i++) begin
            req();
            total++; if (tx_data !== exp_w[i]) begin bad++; $display("FAIL basic_word%0d got=%h exp=%h", i, tx_data, exp_w[i]); end
        end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL basic_level0 got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_gap_header();
        logic [31:0] exp_w [4] = '{32'hA55A0001, 32'h00070008, 32'h0009000A, 32'h000B000C};
        int k;
        for (int i = 7; i <= 12; i++) feed(16'(i));
        total++; if (fifo_level !== 4'd3) begin bad++; $display("FAIL gap_level3 got=%0d exp=3", fifo_level); end
        pulse_done();
        k = 1;
        while (tx_start_en !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        total++; if (k != 11) begin bad++; $display("FAIL gap_len got=%0d exp=11", k); end
        total++; if (start_cnt != 2) begin bad++; $display("FAIL gap_start_cnt got=%0d exp=2", start_cnt); end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            req();
            total++; if (tx_data !== exp_w[i]) begin bad++; $display("FAIL gap_word%0d got=%h exp=%h", i, tx_data, exp_w[i]); end
        end
    endtask

    task automatic test_overrun_words();
        feed(16'h00D0);
        feed(16'h00E0);
        for (int i = 0; i < 2; i++) begin
            req();
            total++; if (tx_data !== 32'd0) begin bad++; $display("FAIL extra_word%0d got=%h exp=00000000", i, tx_data); end
            total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL extra_level%0d got=%0d exp=1", i, fifo_level); end
        end
        pulse_done();
        repeat (11) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL extra_idle_busy got=%b exp=0", busy); end
        total++; if (start_cnt != 2) begin bad++; $display("FAIL extra_start_cnt got=%0d exp=2", start_cnt); end
    endtask

    task automatic test_overflow();
        int p;
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            feed(16'h2000 + 16'(i));
            if (i % 2 == 0) begin
                p = i / 2;
                total++; if (fifo_level !== 4'(p > 8 ? 8 : p)) begin bad++; $display("FAIL ovf_level_p%0d got=%0d exp=%0d", p, fifo_level, (p > 8 ? 8 : p)); end
                total++; if (overflow !== (p > 8)) begin bad++; $display("FAIL ovf_flag_p%0d got=%b exp=%b", p, overflow, (p > 8)); end
            end
        end
        ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
        feed(16'h2015);
        smp_valid = 1'b1; smp_data = 16'h2016; ovf_clr = 1'b1;
        @(negedge clk);
        smp_valid = 1'b0; ovf_clr = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
        ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr2 got=%b exp=0", overflow); end
        req();
        total++; if (tx_data !== 32'hA55A0000) begin bad++; $display("FAIL ovf_hdr got=%h exp=A55A0000", tx_data); end
        req();
        total++; if (tx_data !== 32'h20012002) begin bad++; $display("FAIL ovf_word1 got=%h exp=20012002", tx_data); end
        total++; if (fifo_level !== 4'd7) begin bad++; $display("FAIL ovf_level7 got=%0d exp=7", fifo_level); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_w [4] = '{32'hA55A0001, 32'h10071008, 32'h1009100A, 32'h100B100C};
        int k;
        do_reset();
        for (int i = 1; i <= 6; i++) feed(16'h1000 + 16'(i));
        wait_start(k);
        total++; if (k >= 40) begin bad++; $display("FAIL stream_start1 got=timeout exp=start"); end
        @(negedge clk);
        req();
        total++; if (tx_data !== 32'hA55A0000) begin bad++; $display("FAIL stream_hdr0 got=%h exp=A55A0000", tx_data); end
        for (int j = 0; j < 2; j++) begin
            feed(16'h1007 + 16'(2 * j));
            smp_valid = 1'b1; smp_data = 16'h1008 + 16'(2 * j); tx_req = 1'b1;
            @(negedge clk);
            smp_valid = 1'b0; tx_req = 1'b0;
            total++; if (fifo_level !== 4'd3) begin bad++; $display("FAIL stream_wrpop_level%0d got=%0d exp=3", j, fifo_level); end
            total++; if (tx_data !== (j == 0 ? 32'h10011002 : 32'h10031004)) begin bad++; $display("FAIL stream_wrpop_data%0d got=%h", j, tx_data); end
        end
        req();
        total++; if (tx_data !== 32'h10051006) begin bad++; $display("FAIL stream_word3 got=%h exp=10051006", tx_data); end
        total++; if (fifo_level !== 4'd2) begin bad++; $display("FAIL stream_level2 got=%0d exp=2", fifo_level); end
        pulse_done();
        feed(16'h100B);
        feed(16'h100C);
        wait_start(k);
        total++; if (k >= 40) begin bad++; $display("FAIL stream_start2 got=timeout exp=start"); end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            req();
            total++; if (tx_data !== exp_w[i]) begin bad++; $display("FAIL stream_p2_word%0d got=%h exp=%h", i, tx_data, exp_w[i]); end
        end
        pulse_done();
    endtask

    task automatic test_reset_midpacket();
        int k;
        int cnt0;
        for (int i = 1; i <= 6; i++) feed(16'h3000 + 16'(i));
        wait_start(k);
        total++; if (k >= 40) begin bad++; $display("FAIL mid_start got=timeout exp=start"); end
        @(negedge clk);
        req();
        total++; if (tx_data !== 32'hA55A0002) begin bad++; $display("FAIL mid_hdr got=%h exp=A55A0002", tx_data); end
        req();
        total++; if (tx_data !== 32'h30013002) begin bad++; $display("FAIL mid_word1 got=%h exp=30013002", tx_data); end
        feed(16'h3007);
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (tx_start_en !== 1'b0) begin bad++; $display("FAIL mid_rst_start got=%b exp=0", tx_start_en); end
        total++; if (tx_byte_num !== 16'd0) begin bad++; $display("FAIL mid_rst_bytes got=%h exp=0000", tx_byte_num); end
        total++; if (tx_data !== 32'd0) begin bad++; $display("FAIL mid_rst_data got=%h exp=00000000", tx_data); end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL mid_rst_level got=%0d exp=0", fifo_level); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        cnt0 = start_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        total++; if (start_cnt != cnt0) begin bad++; $display("FAIL mid_no_start got=%0d exp=%0d", start_cnt, cnt0); end
        for (int i = 1; i <= 6; i++) feed(16'h4000 + 16'(i));
        wait_start(k);
        total++; if (k != 1) begin bad++; $display("FAIL mid_restart_latency got=%0d exp=1", k); end
        @(negedge clk);
        req();
        total++; if (tx_data !== 32'hA55A0000) begin bad++; $display("FAIL mid_new_hdr got=%h exp=A55A0000", tx_data); end
        req();
        total++; if (tx_data !== 32'h40014002) begin bad++; $display("FAIL mid_new_word1 got=%h exp=40014002", tx_data); end
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_gap_header();
        test_overrun_words();
        test_overflow();
        test_stream();
        test_reset_midpacket();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
